// File: rtl/rwl_driver.sv
// Read-word-line driver: serializes one bit of 8 words onto an active-low RWL bank.
// Optional RWLDRV_GATE_EN adds rwl_en; when low both banks are held deasserted.
module rwl_driver #(
  parameter int NROW  = 8,
  parameter int WBITS = 24,
  parameter int HBITS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NROW*WBITS-1:0] xin0,
  input  logic [5:0]            sel,
  input  logic                  cima,
  input  logic                  inwidth,
`ifdef RWLDRV_GATE_EN
  input  logic                  rwl_en,
`endif
  output logic [NROW-1:0]       rwlb_row0,
  output logic [NROW-1:0]       rwlb_row1
);

  localparam int BW = $clog2(WBITS);

  logic [5:0]      w_top;
  logic [5:0]      w_bidx;
  logic            w_valid;
  logic            w_en;
  logic [NROW-1:0] w_s;
  logic [NROW-1:0] r_row0;
  logic [NROW-1:0] r_row1;

  assign w_top   = inwidth ? 6'(WBITS-1) : 6'(HBITS-1);
  assign w_bidx  = w_top - sel;
  assign w_valid = (sel <= w_top);

`ifdef RWLDRV_GATE_EN
  assign w_en = rwl_en;
`else
  assign w_en = 1'b1;
`endif

  always_comb begin
    w_s = '0;
    for (int i = 0; i < NROW; i++) begin
      w_s[i] = xin0[i*WBITS + int'(w_bidx[BW-1:0])];
    end
  end

  // Inactive bank is always all-ones; out-of-range sel idles both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row0 <= '1;
      r_row1 <= '1;
    end else if (!w_en || !w_valid) begin
      r_row0 <= '1;
      r_row1 <= '1;
    end else if (cima) begin
      r_row0 <= '1;
      r_row1 <= ~w_s;
    end else begin
      r_row0 <= ~w_s;
      r_row1 <= '1;
    end
  end

  assign rwlb_row0 = r_row0;
  assign rwlb_row1 = r_row1;

endmodule

// File: tb/tb_rwl_driver.sv
// Directed bench for rwl_driver: hand vectors, reset mid-sweep, full sweeps vs bit model.
module tb_rwl_driver;

  logic         clk;
  logic         rst_n;
  logic [191:0] xin0;
  logic [5:0]   sel;
  logic         cima;
  logic         inwidth;
  logic [7:0]   rwlb_row0;
  logic [7:0]   rwlb_row1;

  int n_tests;
  int n_fail;

  rwl_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xin0      (xin0),
    .sel       (sel),
    .cima      (cima),
    .inwidth   (inwidth),
    .rwlb_row0 (rwlb_row0),
    .rwlb_row1 (rwlb_row1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got row0/row1=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic iw, input logic cm,
                                        input int sl);
    int         top;
    int         b;
    logic [23:0] w;
    logic [7:0]  s;
    top = iw ? 23 : 11;
    if (sl > top) return 16'hFFFF;
    b = top - sl;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      w = 24'hAAAAAA + 24'(i);
      s[i] = w[b];
    end
    return cm ? {8'hFF, ~s} : {~s, 8'hFF};
  endfunction

  task automatic step(input logic iw, input logic cm, input int sl);
    inwidth = iw;
    cima    = cm;
    sel     = 6'(sl);
    @(posedge clk);
    #1;
  endtask

  task automatic load_base();
    for (int i = 0; i < 8; i++) xin0[i*24 +: 24] = 24'hAAAAAA + 24'(i);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    inwidth = 1'b1;
    cima    = 1'b0;
    sel     = 6'd0;
    load_base();
    @(posedge clk);
    #1;
    chk("reset", {rwlb_row0, rwlb_row1}, 16'hFFFF);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 0);
    chk("h_c0_s0", {rwlb_row0, rwlb_row1}, 16'h00FF);
    step(1'b0, 1'b0, 11);
    chk("h_c0_s11", {rwlb_row0, rwlb_row1}, 16'h55FF);
    step(1'b0, 1'b1, 11);
    chk("h_c1_s11", {rwlb_row0, rwlb_row1}, 16'hFF55);
    step(1'b0, 1'b1, 12);
    chk("h_c1_s12", {rwlb_row0, rwlb_row1}, 16'hFFFF);
    step(1'b1, 1'b0, 19);
    chk("f_c0_s19", {rwlb_row0, rwlb_row1}, 16'h3FFF);
    step(1'b1, 1'b0, 0);
    chk("f_c0_s0", {rwlb_row0, rwlb_row1}, 16'h00FF);
    step(1'b1, 1'b1, 23);
    chk("f_c1_s23", {rwlb_row0, rwlb_row1}, 16'hFF55);
    step(1'b1, 1'b1, 24);
    chk("f_c1_s24", {rwlb_row0, rwlb_row1}, 16'hFFFF);
    step(1'b1, 1'b1, 63);
    chk("f_c1_s63", {rwlb_row0, rwlb_row1}, 16'hFFFF);

    // Upper bits must be ignored in 12-bit mode
    for (int i = 0; i < 8; i++) xin0[i*24+12 +: 12] = 12'h555;
    step(1'b0, 1'b0, 0);
    chk("h_upper_ign", {rwlb_row0, rwlb_row1}, 16'h00FF);
    step(1'b1, 1'b0, 0);
    chk("f_upper_used", {rwlb_row0, rwlb_row1}, 16'hFFFF);
    load_base();

    step(1'b1, 1'b0, 4);
    chk("pre_rst_s4", {rwlb_row0, rwlb_row1}, 16'h00FF);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 5);
    chk("mid_rst", {rwlb_row0, rwlb_row1}, 16'hFFFF);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4);
    chk("post_rst_s4", {rwlb_row0, rwlb_row1}, 16'h00FF);

    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s <= ((m & 2) ? 24 : 12); s++) begin
        step(m[1], m[0], s);
        chk($sformatf("sweep_w%0d_c%0d_s%0d", m[1], m[0], s),
            {rwlb_row0, rwlb_row1}, model(m[1], m[0], s));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
